// File: rtl/vram_pkg.sv
// Shared types and defaults for the video RAM arbiter.
// Owner tags follow a read through the RAM pipeline.
package vram_pkg;

    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } own_e;

endpackage

// File: rtl/vram_arbiter.sv
// VGA-priority arbiter for the single-port video RAM.
// The CPU is forced a grant after MAX_WAIT lost edges.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_stall,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

    logic [WC_W-1:0] wait_cnt;
    own_e            s1_own;
    own_e            s2_own;
    own_e            s1_nxt;
    logic            force_cpu;

    always_comb begin
        force_cpu = (wait_cnt == WAIT_MAX);
        vga_gnt   = rst & vga_req & ~(cpu_req & force_cpu);
        cpu_gnt   = rst & cpu_req & (~vga_req | force_cpu);
    end

    assign vga_stall  = vga_req & ~vga_gnt;
    assign vga_rvalid = (s2_own == OWN_VGA);
    assign cpu_rvalid = (s2_own == OWN_CPU);
    assign vga_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;

    // Writes need no response, so they enter the pipe untagged.
    always_comb begin
        s1_nxt = OWN_NONE;
        unique case (1'b1)
            vga_gnt:             s1_nxt = OWN_VGA;
            (cpu_gnt & ~cpu_we): s1_nxt = OWN_CPU;
            default:             s1_nxt = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_own    <= OWN_NONE;
            s2_own    <= OWN_NONE;
        end else begin
            if (cpu_req & ~cpu_gnt) begin
                if (!force_cpu) wait_cnt <= wait_cnt + WC_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            mem_en <= vga_gnt | cpu_gnt;
            mem_we <= cpu_gnt & cpu_we;
            if (vga_gnt) begin
                mem_addr <= vga_addr;
            end else if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end
            s1_own <= s1_nxt;
            s2_own <= s1_own;
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-port arbiter that shares the single-port synchronous video RAM between the VGA scan-out reader and the CPU's memory-mapped framebuffer port. The VGA reader has priority. The CPU is protected by a bounded starvation counter. The block sits between the `mips0` data-memory decode and the VGA timing generator, inside `cpu`, and feeds the 8-bit RGB 3-3-2 pixel path behind `red_out`, `green_out` and `blue_out`.

## Interface
- `ADDR_W`, default 15: VRAM word-address width.
- `DATA_W`, default 8: pixel width (R3 G3 B2).
- `MAX_WAIT`, default 4: edges the CPU may lose before it is forced a grant. Must be ≥1.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, asynchronous, active-low.
- `vga_req`  in  1  VGA read request.
- `vga_addr`  in  ADDR_W  VGA read address.
- `vga_gnt`  out  1  VGA request accepted this edge (combinational).
- `vga_rvalid`  out  1  `vga_rdata` valid.
- `vga_rdata`  out  DATA_W  read data.
- `vga_stall`  out  1  `vga_req & ~vga_gnt`; underflow monitor.
- `cpu_req`  in  1  CPU request.
- `cpu_we`  in  1  CPU request is a write.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_gnt`  out  1  CPU request accepted this edge (combinational).
- `cpu_rvalid`  out  1  `cpu_rdata` valid (reads only).
- `cpu_rdata`  out  DATA_W  read data.
- `mem_en`, `mem_we`  out  1  RAM command strobes (registered).
- `mem_addr`  out  ADDR_W  RAM address (registered).
- `mem_wdata`  out  DATA_W  RAM write data (registered).
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after the command cycle.

## Operation
- Handshake is valid/ready per port. A transfer occurs at the rising edge where `req & gnt` = 1. The requester holds `req`, `addr`, `we` and `wdata` stable until that edge. It may present a new request in the following cycle, so each port can transfer every cycle.
- Arbitration is combinational from `vga_req`, `cpu_req` and the registered `wait_cnt`:
  - Only one port requesting: that port is granted.
  - Both requesting and `wait_cnt == MAX_WAIT`: CPU is granted.
  - Otherwise: VGA is granted.
  - At most one `gnt` is high in any cycle.
  - Both `gnt` are 0 while `rst` = 0.
- `wait_cnt`, width `$clog2(MAX_WAIT+1)`:
  - On each edge with `cpu_req & ~cpu_gnt`: increments, saturating at `MAX_WAIT`.
  - On a CPU grant or `cpu_req = 0`: clears to 0.
- Pipeline registers:
  - `s1_own`, values NONE/VGA/CPU, loaded with the accepted read's owner. Writes load NONE.
  - `s2_own` follows `s1_own`.
  - `vga_rvalid = (s2_own == VGA)`, `cpu_rvalid = (s2_own == CPU)`.
  - Both `rdata` outputs are `mem_rdata` passthrough and are meaningful only with their `rvalid`.
- RAM command: on an accepting edge, `mem_en` = 1, `mem_we = cpu_we & cpu_gnt`, and the granted port's address and data are registered. With no transfer, `mem_en` and `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last value.
- CPU writes complete at acceptance. No response is returned.
- Ordering: commands reach the RAM in acceptance order. A read accepted on any edge after a write to the same address returns the new data.
- Reset values (all outputs, any time `rst` = 0): `mem_en` = `mem_we` = 0, `mem_addr` = `mem_wdata` = 0, `s1_own` = `s2_own` = NONE (so both `rvalid` = 0), `wait_cnt` = 0.
- Reset asserted mid-operation: in-flight reads are dropped and no `rvalid` is produced for them. A RAM write already in its command cycle is not retracted.

## Timing
- Accept at edge E0 → RAM command visible in cycle E0–E1 → `mem_rdata` and `rvalid` in cycle E1–E2. Read latency is 2 cycles from acceptance.
- Throughput: one transfer per cycle in total. Under continuous contention VGA gets `MAX_WAIT` grants, then the CPU gets 1, repeating.
- Combinational paths: `req` → `gnt` and `mem_rdata` → `rdata`. All other outputs are registered.

## Structure
- Shared package `vram_pkg` holds:
  - the owner encoding `OWN_NONE`=2'd0, `OWN_VGA`=2'd1, `OWN_CPU`=2'd2;
  - defaults for `ADDR_W`, `DATA_W` and `MAX_WAIT`.
- Single flat module. No sub-module is needed; the RAM itself lives outside the block.

## Test plan
- **Reset:** hold `rst`=0 with both `req`=1 → both `gnt`, `mem_en`, `mem_we` and both `rvalid` = 0; `mem_addr` = 0.
- **VGA streaming:** RAM preloaded with 0x00–0x0F, VGA requests addresses 0..15 back-to-back with the CPU idle → 16 consecutive grants; `vga_rvalid` high for 16 cycles starting 2 cycles after the first accept; data 0x00..0x0F in order.
- **CPU write then read:** write 0x5A to 0x100, then read 0x100 → `mem_we` pulses for one cycle; `cpu_rvalid` 2 cycles after the read accept with `cpu_rdata` = 0x5A.
- **Starvation:** `MAX_WAIT`=4, both requesting continuously → grant pattern V V V V C repeating; `wait_cnt` sequence 1,2,3,4,0; `vga_stall` high exactly on CPU-grant cycles.
- **Write-before-read:** CPU writes 0xE3 to 0x020 at edge E0, VGA reads 0x020 at E1 → `vga_rdata` = 0xE3 in cycle E2–E3.
- **Reset mid-read:** VGA read accepted at E0, `rst` driven low during cycle E0–E1 → no `vga_rvalid` at any time; after release, a new read returns the correct data with 2-cycle latency.
